wb_trace_buffer: RTL and testbench

//   Downstream consumer of the processor's register-file write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg).

---
 rtl/wb_trace_pkg.sv | 16 +
 rtl/wb_trace_buffer_if.sv | 27 ++
 rtl/trace_fifo.sv | 67 ++++++
 rtl/wb_trace_buffer.sv | 79 +++++++
 tb/tb_wb_trace_buffer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared widths, trace record type and drop-counter limit
package wb_trace_pkg;

    localparam int DEF_CYC_W  = 10;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        logic [DEF_CYC_W-1:0]  cycle;
        logic [DEF_REG_W-1:0]  rd;
        logic [DEF_DATA_W-1:0] data;
    } trace_rec_t;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - register write-back capture port plus record drain stream
interface wb_trace_buffer_if
    import wb_trace_pkg::*;
#(
    parameter int CYC_W  = DEF_CYC_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              wb_we;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [CYC_W-1:0]  out_cycle;
    logic [REG_W-1:0]  out_rd;
    logic [DATA_W-1:0] out_data;

    modport master (
        output wb_we, wb_rd, wb_data, out_ready,
        input  out_valid, out_cycle, out_rd, out_data
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, out_ready,
        output out_valid, out_cycle, out_rd, out_data
    );
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic first-word-fall-through FIFO, DEPTH entries of W bits
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (PW+1)'(1);
                2'b01:   cnt_d = cnt_q - (PW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - timestamps register-file writes and queues them for a valid/ready reader
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CYC_W  = DEF_CYC_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   freeze,
    wb_trace_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drop_count
);
    localparam int REC_W = CYC_W + REG_W + DATA_W;

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic             capture, pop, drop, full, empty;
    logic [REC_W-1:0] wr_rec, rd_rec;

    assign capture = bus.wb_we && (bus.wb_rd != '0) && !freeze;
    assign pop     = !empty && bus.out_ready;
    assign drop    = capture && full && !pop;
    assign wr_rec  = {cyc_q, bus.wb_rd, bus.wb_data};

    always_comb begin
        cyc_d  = cyc_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clear) begin
            cyc_d  = '0;
            ovf_d  = 1'b0;
            drop_d = '0;
        end else begin
            if (!freeze) cyc_d = cyc_q + CYC_W'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (capture),
        .pop   (pop),
        .wdata (wr_rec),
        .rdata (rd_rec),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Record fields read as zero while empty so the stream is clean out of reset.
    assign bus.out_valid = !empty;
    assign {bus.out_cycle, bus.out_rd, bus.out_data} = empty ? '0 : rd_rec;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - directed scoreboard bench for wb_trace_buffer
module tb_wb_trace_buffer;
    import wb_trace_pkg::*;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       freeze = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] drop_count;

    wb_trace_buffer_if bus ();

    wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .freeze     (freeze),
        .bus        (bus),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    trace_rec_t sb[$];
    logic [DEF_CYC_W-1:0] m_cyc = '0;
    logic                 m_ovf = 1'b0;
    logic [7:0]           m_drop = '0;

    // Reference model advanced from the bench's own inputs on every active edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb.delete();
            m_cyc  = '0;
            m_ovf  = 1'b0;
            m_drop = '0;
        end else if (clear) begin
            sb.delete();
            m_cyc  = '0;
            m_ovf  = 1'b0;
            m_drop = '0;
        end else begin
            trace_rec_t rec;
            rec = '{cycle: m_cyc, rd: bus.wb_rd, data: bus.wb_data};
            if (bus.out_ready && sb.size() != 0) void'(sb.pop_front());
            if (bus.wb_we && bus.wb_rd != 0 && !freeze) begin
                if (sb.size() < DEPTH) sb.push_back(rec);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
                end
            end
            if (!freeze) m_cyc = m_cyc + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0)
            chk("head_rec", 64'({bus.out_cycle, bus.out_rd, bus.out_data}), 64'(sb[0]));
        chk("count", 64'(count), 64'(sb.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        check_state();
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        bus.wb_we   = we;
        bus.wb_rd   = rd;
        bus.wb_data = data;
    endtask

    logic [DEF_CYC_W-1:0] s;

    initial begin
        wb(1'b0, '0, '0);
        bus.out_ready = 1'b0;
        @(negedge clock);
        tick();
        chk("reset_rec", 64'({bus.out_cycle, bus.out_rd, bus.out_data}), 64'd0);
        chk("reset_valid", 64'(bus.out_valid), 64'd0);

        // 1: single write, appears one cycle later, then drains
        reset = 1'b1;
        bus.out_ready = 1'b1;
        wb(1'b1, 5'd3, 32'd7);
        tick();
        chk("t1_rec", 64'({bus.out_valid, bus.out_cycle, bus.out_rd, bus.out_data}),
            64'({1'b1, 10'd0, 5'd3, 32'd7}));
        wb(1'b0, '0, '0);
        tick();
        chk("t1_empty", 64'(bus.out_valid), 64'd0);

        // 2: writes to r0 are ignored but time still advances
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wb(1'b1, 5'd0, 32'hdead);
        repeat (5) tick();
        chk("t2_count", 64'(count), 64'd0);
        wb(1'b1, 5'd1, 32'h1);
        tick();
        chk("t2_stamp", 64'(bus.out_cycle), 64'd5);
        wb(1'b0, '0, '0);
        tick();

        // 3: overfill then drain in order
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            wb(1'b1, 5'((i % 31) + 1), $urandom);
            tick();
        end
        wb(1'b0, '0, '0);
        chk("t3_count", 64'(count), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_count), 64'd3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_stamp", 64'(bus.out_cycle), 64'(i));
            tick();
        end
        chk("t3_drained", 64'(bus.out_valid), 64'd0);

        // 4: push+pop while full, then clear beats a push
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wb(1'b1, 5'd7, 32'(i));
            tick();
        end
        bus.out_ready = 1'b1;
        wb(1'b1, 5'd8, 32'h55);
        tick();
        chk("t4_full_count", 64'(count), 64'd16);
        chk("t4_no_drop", 64'(drop_count), 64'd3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_clr_count", 64'(count), 64'd0);
        chk("t4_clr_ovf", 64'(overflow), 64'd0);
        chk("t4_clr_drop", 64'(drop_count), 64'd0);
        wb(1'b1, 5'd2, 32'h22);
        tick();
        chk("t4_clr_stamp", 64'(bus.out_cycle), 64'd0);
        wb(1'b0, '0, '0);
        tick();

        // 5: freeze halts stamping and capture, drain continues; then wrap
        bus.out_ready = 1'b0;
        s = m_cyc;
        wb(1'b1, 5'd4, 32'h44);
        tick();
        tick();
        freeze = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("t5_frz_drained", 64'(count), 64'd0);
        freeze = 1'b0;
        tick();
        chk("t5_resume_stamp", 64'(bus.out_cycle), 64'(10'(s + 10'd2)));
        wb(1'b0, '0, '0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (1023) tick();
        bus.out_ready = 1'b0;
        wb(1'b1, 5'd5, 32'h5);
        tick();
        chk("t5_stamp_max", 64'(bus.out_cycle), 64'd1023);
        bus.out_ready = 1'b1;
        tick();
        chk("t5_stamp_wrap", 64'(bus.out_cycle), 64'd0);
        wb(1'b0, '0, '0);
        tick();

        // 6: asynchronous reset mid-cycle discards queued records
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb(1'b1, 5'd6, 32'(i + 100));
            tick();
        end
        wb(1'b0, '0, '0);
        chk("t6_queued", 64'(count), 64'd5);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_async_count", 64'(count), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        wb(1'b1, 5'd9, 32'h99);
        tick();
        chk("t6_first_stamp", 64'({bus.out_cycle, bus.out_rd}), 64'({10'd0, 5'd9}));
        wb(1'b0, '0, '0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
